// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding, parity codes and line levels for the UART transmit path
package uart_tx_pkg;
  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_t;
  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
endpackage

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: computes and holds the frame parity bit and parity enable at byte acceptance
module uart_tx_parity
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  par_bit,
  output logic                  par_en_q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
    end else if (en) begin
      par_bit  <= (^parallel_data) ^ (par_typ == PAR_ODD);
      par_en_q <= par_en;
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame sequencer driving start, data (via serializer), parity and stop bits
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  ser_done,
  input  logic                  serial_data,
  output logic                  ser_enable,
  output logic                  busy,
  output logic                  tx_out,
  output logic                  tx_done
);
  uart_state_t state, nxt;
  logic accept, par_bit, par_en_q;
  assign accept = (state == UART_IDLE) && data_valid;
  uart_tx_parity #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .clk(clk),
    .rst(rst),
    .en(accept),
    .parallel_data(parallel_data),
    .par_en(par_en),
    .par_typ(par_typ),
    .par_bit(par_bit),
    .par_en_q(par_en_q)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= UART_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      UART_IDLE:   nxt = data_valid ? UART_START : UART_IDLE;
      UART_START:  nxt = UART_DATA;
      UART_DATA:   nxt = !ser_done ? UART_DATA : par_en_q ? UART_PARITY : UART_STOP;
      UART_PARITY: nxt = UART_STOP;
      default:     nxt = UART_IDLE;
    endcase
    busy       = state != UART_IDLE;
    ser_enable = state == UART_DATA;
    tx_done    = state == UART_STOP;
    tx_out     = state == UART_START  ? LINE_START :
                 state == UART_DATA   ? serial_data :
                 state == UART_PARITY ? par_bit : LINE_IDLE;
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed checks of uart_tx_ctrl against a behavioural 8-bit serializer
module tb_uart_tx_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] parallel_data = 8'h00;
  logic       data_valid = 1'b0, par_en = 1'b0, par_typ = 1'b0;
  logic       ser_done, serial_data, ser_enable, busy, tx_out, tx_done;
  logic [7:0] sh;
  logic [2:0] cnt;
  logic       tx [32], bz [32], dn [32], se [32];
  int         total = 0, bad = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .parallel_data(parallel_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .ser_done(ser_done), .serial_data(serial_data),
    .ser_enable(ser_enable), .busy(busy), .tx_out(tx_out), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // serializer: loads on accept, shifts LSB first while enabled, done at count 7
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sh  <= 8'h00;
      cnt <= 3'd0;
    end else if (data_valid && !busy) begin
      sh  <= parallel_data;
      cnt <= 3'd0;
    end else if (ser_enable) begin
      sh  <= sh >> 1;
      cnt <= cnt + 3'd1;
    end else cnt <= 3'd0;
  assign serial_data = sh[0];
  assign ser_done    = ser_enable && cnt == 3'd7;

  task automatic start(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk);
    parallel_data = d;
    par_en = pe;
    par_typ = pt;
    data_valid = 1'b1;
  endtask

  task automatic rec(input int from, input int to, input bit tog, input bit hold);
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      tx[i] = tx_out;
      bz[i] = busy;
      dn[i] = tx_done;
      se[i] = ser_enable;
      data_valid = hold | (tog & (i % 2 == 0) & (i < 9));
    end
  endtask

  task automatic test_reset;
    #3;
    total++;
    if ({tx_out, busy, ser_enable, tx_done} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=1000", {tx_out, busy, ser_enable, tx_done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({tx_out, busy} !== 2'b10) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=10", {tx_out, busy});
    end
  endtask

  task automatic test_even;
    logic exp [11] = '{0,1,0,1,0,0,1,0,1,0,1};
    int nb = 0, nd = 0;
    start(8'hA5, 1'b1, 1'b0);
    rec(0, 13, 0, 0);
    for (int i = 0; i < 11; i++) begin
      total++;
      if (tx[i] !== exp[i]) begin
        bad++;
        $display("FAIL even_a5_bit%0d got=%b want=%b", i, tx[i], exp[i]);
      end
    end
    for (int i = 0; i < 13; i++) begin
      nb += int'(bz[i]);
      nd += int'(dn[i]);
    end
    total++;
    if (nb != 11 || nd != 1 || dn[10] !== 1'b1) begin
      bad++;
      $display("FAIL even_busy_done busy=%0d done=%0d done10=%b want 11 1 1", nb, nd, dn[10]);
    end
    total++;
    if (tx[11] !== 1'b1 || bz[11] !== 1'b0) begin
      bad++;
      $display("FAIL even_back_idle tx=%b busy=%b want 1 0", tx[11], bz[11]);
    end
  endtask

  task automatic test_odd;
    start(8'h01, 1'b1, 1'b1);
    rec(0, 12, 0, 0);
    total++;
    if (tx[9] !== 1'b0 || tx[1] !== 1'b1 || tx[2] !== 1'b0) begin
      bad++;
      $display("FAIL odd_01_parity par=%b d0=%b d1=%b want 0 1 0", tx[9], tx[1], tx[2]);
    end
    start(8'h01, 1'b1, 1'b0);
    rec(0, 12, 0, 0);
    total++;
    if (tx[9] !== 1'b1 || tx[10] !== 1'b1 || dn[10] !== 1'b1) begin
      bad++;
      $display("FAIL even_01_parity par=%b stop=%b done=%b want 1 1 1", tx[9], tx[10], dn[10]);
    end
  endtask

  task automatic test_no_parity;
    int nb = 0, ns = 0, ones = 0;
    start(8'hFF, 1'b0, 1'b0);
    rec(0, 12, 0, 0);
    for (int i = 0; i < 12; i++) begin
      nb += int'(bz[i]);
      ns += int'(se[i]);
    end
    for (int i = 1; i < 9; i++) ones += int'(tx[i]);
    total++;
    if (tx[0] !== 1'b0 || ones != 8 || tx[9] !== 1'b1) begin
      bad++;
      $display("FAIL nopar_frame start=%b ones=%0d stop=%b want 0 8 1", tx[0], ones, tx[9]);
    end
    total++;
    if (nb != 10 || ns != 8 || dn[9] !== 1'b1) begin
      bad++;
      $display("FAIL nopar_len busy=%0d ser_en=%0d done9=%b want 10 8 1", nb, ns, dn[9]);
    end
  endtask

  task automatic test_back_to_back;
    logic e1 [11] = '{0,0,0,1,1,1,1,0,0,0,1};
    logic e2 [11] = '{0,1,1,0,0,0,0,1,1,0,1};
    int nb = 0;
    start(8'h3C, 1'b1, 1'b0);
    rec(0, 5, 0, 1);
    parallel_data = 8'hC3;
    rec(5, 23, 0, 1);
    data_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      total++;
      if (tx[i] !== e1[i] || tx[i+12] !== e2[i]) begin
        bad++;
        $display("FAIL b2b_bit%0d got=%b/%b want=%b/%b", i, tx[i], tx[i+12], e1[i], e2[i]);
      end
    end
    total++;
    if (bz[11] !== 1'b0 || bz[12] !== 1'b1 || bz[10] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_period busy10..12=%b%b%b want 101", bz[10], bz[11], bz[12]);
    end
    repeat (3) @(negedge clk);
    start(8'hA5, 1'b1, 1'b0);
    rec(0, 13, 1, 0);
    for (int i = 0; i < 13; i++) nb += int'(bz[i]);
    total++;
    if (nb != 11 || bz[12] !== 1'b0 || tx[9] !== 1'b0) begin
      bad++;
      $display("FAIL busy_toggle busy=%0d busy12=%b par=%b want 11 0 0", nb, bz[12], tx[9]);
    end
  endtask

  task automatic test_config_change;
    int nb = 0;
    start(8'h01, 1'b1, 1'b0);
    rec(0, 4, 0, 0);
    par_en = 1'b0;
    par_typ = 1'b1;
    parallel_data = 8'h03;
    rec(4, 12, 0, 0);
    total++;
    if (tx[9] !== 1'b1 || dn[10] !== 1'b1 || bz[11] !== 1'b0) begin
      bad++;
      $display("FAIL cfg_old_frame par=%b done10=%b busy11=%b want 1 1 0", tx[9], dn[10], bz[11]);
    end
    start(8'h03, 1'b0, 1'b1);
    rec(0, 12, 0, 0);
    for (int i = 0; i < 12; i++) nb += int'(bz[i]);
    total++;
    if (nb != 10 || dn[9] !== 1'b1 || tx[9] !== 1'b1) begin
      bad++;
      $display("FAIL cfg_new_frame busy=%0d done9=%b stop=%b want 10 1 1", nb, dn[9], tx[9]);
    end
  endtask

  task automatic test_reset_mid_data;
    logic exp [11] = '{0,0,1,0,1,1,0,1,0,0,1};
    start(8'h5A, 1'b1, 1'b0);
    rec(0, 4, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({tx_out, busy, ser_enable, tx_done} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_mid_data got=%b want=1000", {tx_out, busy, ser_enable, tx_done});
    end
    @(negedge clk);
    rst = 1'b1;
    start(8'h5A, 1'b1, 1'b0);
    rec(0, 12, 0, 0);
    for (int i = 0; i < 11; i++) begin
      total++;
      if (tx[i] !== exp[i]) begin
        bad++;
        $display("FAIL post_reset_5a_bit%0d got=%b want=%b", i, tx[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_even;
    test_odd;
    test_no_parity;
    test_back_to_back;
    test_config_change;
    test_reset_mid_data;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
